// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multicycle RV32I datapath. It sequences each
// instruction through fetch, decode, execute and writeback, issues the ALU
// operation code and operand selects, and traps on unsupported encodings.
//
// Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
// ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
//
// Ports
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_opcode       instruction register [6:0]
//   i_funct3       instruction register [14:12]
//   i_funct7b5     instruction register [30]
//   i_zero         ALU zero flag (used by beq)
//   i_mem_ready    memory completes the current access this cycle
//   o_pc_write     PC load enable
//   o_adr_src      memory address select: 0 = PC, 1 = ALUOut
//   o_ir_write     instruction register / oldPC load
//   o_mem_write    memory write request
//   o_reg_write    register file write enable
//   o_result_src   00 = ALUOut, 01 = read data, 10 = ALU result
//   o_alu_src_a    00 = PC, 01 = oldPC, 10 = rs1
//   o_alu_src_b    00 = rs2, 01 = immediate, 10 = constant 4
//   o_alu_control  ALU operation code
//   o_instr_done   one-cycle pulse in an instruction's final cycle
//   o_illegal      high while trapped
//   o_state        current state, for debug and verification
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [3:0] o_alu_control,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  state_e     r_state;
  state_e     w_next_state;

  // Raw decodes before the reset-cycle gating of the enables.
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_instr_done;
  logic       w_illegal;

  // ALU function decode shared by the register and immediate forms.
  logic [3:0] w_alu_funct;
  logic       w_funct_ok;
  logic       w_use_f7;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= state_e'(RESET_STATE);
    end else begin
      r_state <= w_next_state;
    end
  end

  // funct7b5 selects SUB only for the register form; addi has no SUB.
  assign w_use_f7 = (r_state == StExecR);

  always_comb begin
    w_alu_funct = AluAdd;
    w_funct_ok  = 1'b1;
    case (i_funct3)
      3'b000:  w_alu_funct = (w_use_f7 && i_funct7b5) ? AluSub : AluAdd;
      3'b010:  w_alu_funct = AluSlt;
      3'b110:  w_alu_funct = AluOr;
      3'b111:  w_alu_funct = AluAnd;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_instr_done  = 1'b0;
    w_illegal     = 1'b0;
    o_adr_src     = 1'b0;
    o_result_src  = 2'b00;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_alu_control = AluAdd;

    case (r_state)
      StFetch: begin
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
        if (i_mem_ready) w_next_state = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        case (i_opcode)
          OpLoad, OpStore: w_next_state = StMemAdr;
          OpRType:         w_next_state = StExecR;
          OpIType:         w_next_state = StExecI;
          OpBeq:           w_next_state = StBeq;
          OpJal:           w_next_state = StJal;
          default:         w_next_state = StTrap;
        endcase
      end
      StMemAdr: begin
        o_alu_src_a  = 2'b10;
        o_alu_src_b  = 2'b01;
        w_next_state = (i_opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        o_adr_src = 1'b1;
        if (i_mem_ready) w_next_state = StMemWb;
      end
      StMemWb: begin
        o_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = StFetch;
      end
      StMemWrite: begin
        o_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = i_mem_ready;
        if (i_mem_ready) w_next_state = StFetch;
      end
      StExecR: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b00;
        o_alu_control = w_alu_funct;
        w_next_state  = w_funct_ok ? StAluWb : StTrap;
      end
      StExecI: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b01;
        o_alu_control = w_alu_funct;
        w_next_state  = w_funct_ok ? StAluWb : StTrap;
      end
      StAluWb: begin
        o_result_src = 2'b00;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = StFetch;
      end
      StBeq: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b00;
        o_alu_control = AluSub;
        o_result_src  = 2'b00;
        if (i_funct3 == 3'b000) begin
          w_pc_write   = i_zero;
          w_instr_done = 1'b1;
          w_next_state = StFetch;
        end else begin
          w_next_state = StTrap;
        end
      end
      StJal: begin
        // ALU forms the link value while the PC loads the target from ALUOut.
        o_alu_src_a  = 2'b01;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b00;
        w_pc_write   = 1'b1;
        w_next_state = StAluWb;
      end
      default: begin
        // StTrap and the unused encodings 12-15 park here until reset.
        w_illegal    = 1'b1;
        w_next_state = StTrap;
      end
    endcase
  end

  // A reset cycle must never commit architectural state.
  assign o_pc_write   = w_pc_write & i_rst_n;
  assign o_ir_write   = w_ir_write & i_rst_n;
  assign o_mem_write  = w_mem_write & i_rst_n;
  assign o_reg_write  = w_reg_write & i_rst_n;
  assign o_instr_done = w_instr_done & i_rst_n;
  assign o_illegal    = w_illegal & i_rst_n;
  assign o_state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control. Each stimulus cycle pushes the
// expected packed output vector (derived from the state table and the state
// the instruction should be in) and a negedge monitor pops and compares it.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, src_a,
  //  src_b, alu_control, instr_done, illegal, state}
  logic [20:0] exp_q[$];
  logic [20:0] got;

  multicycle_control #(
    .RESET_STATE(4'd0)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_opcode     (opcode),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_pc_write   (pc_write),
    .o_adr_src    (adr_src),
    .o_ir_write   (ir_write),
    .o_mem_write  (mem_write),
    .o_reg_write  (reg_write),
    .o_result_src (result_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_control(alu_control),
    .o_instr_done (instr_done),
    .o_illegal    (illegal),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_control, instr_done, illegal, state};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a given state from the control table.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic mr, input logic z,
                                          input logic rn, input logic [2:0] f3,
                                          input logic f7);
    logic       pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0, done = 0, ill = 0;
    logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00;
    logic [3:0] alu = 4'b0010;
    case (st)
      4'd0: begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      4'd1: begin sa = 2'b01; sb = 2'b01; end
      4'd2: begin sa = 2'b10; sb = 2'b01; end
      4'd3: adr = 1'b1;
      4'd4: begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
      4'd5: begin adr = 1'b1; mw = 1'b1; done = mr; end
      4'd6, 4'd7: begin
        sa = 2'b10;
        sb = (st == 4'd6) ? 2'b00 : 2'b01;
        if (f3 == 3'b000 && st == 4'd6 && f7) alu = 4'b0110;
        else if (f3 == 3'b010) alu = 4'b0111;
        else if (f3 == 3'b110) alu = 4'b0001;
        else if (f3 == 3'b111) alu = 4'b0000;
      end
      4'd8: begin rw = 1'b1; done = 1'b1; end
      4'd9: begin sa = 2'b10; alu = 4'b0110; pcw = z; done = 1'b1; end
      4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      default: ill = 1'b1;
    endcase
    if (!rn) begin
      pcw = 0; irw = 0; mw = 0; rw = 0; done = 0; ill = 0;
    end
    return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, done, ill, st};
  endfunction

  // One clock of stimulus: drive inputs, record what this cycle must show.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input logic rn);
    mem_ready = mr;
    zero      = z;
    rst_n     = rn;
    exp_q.push_back(exp_vec(st, mr, z, rn, funct3, funct7b5));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  // Plain 4-cycle R/I-type flow: fetch, decode, exec, writeback.
  task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    set_instr(op, f3, f7);
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc((op == 7'b0110011) ? 4'd6 : 4'd7, 1, 0, 1);
    cyc(4'd8, 1, 0, 1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [20:0] e;
      e = exp_q.pop_front();
      check_val($sformatf("cycle_state%0d", e[3:0]), {11'd0, got}, {11'd0, e});
    end
  end

  initial begin
    set_instr(7'b0110011, 3'b000, 1'b0);
    rst_n     = 1'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Second reset cycle: state already fetch, enables held off.
    cyc(4'd0, 1, 0, 0);

    // add, sub
    alu_instr(7'b0110011, 3'b000, 1'b0);
    alu_instr(7'b0110011, 3'b000, 1'b1);
    // slt, and, or-immediate, addi with bit 30 set (still ADD)
    alu_instr(7'b0110011, 3'b010, 1'b0);
    alu_instr(7'b0110011, 3'b111, 1'b0);
    alu_instr(7'b0010011, 3'b110, 1'b1);
    alu_instr(7'b0010011, 3'b000, 1'b1);

    // Reset arriving in the writeback cycle of an add.
    set_instr(7'b0110011, 3'b000, 1'b0);
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc(4'd6, 1, 0, 1);
    cyc(4'd8, 1, 0, 0);
    cyc(4'd0, 1, 0, 0);
    // Post-reset fetch, stalled once.
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(4'd0, 0, 0, 1);

    // lw with three wait cycles in MEMREAD: 8 cycles from fetch.
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc(4'd2, 1, 0, 1);
    cyc(4'd3, 0, 0, 1);
    cyc(4'd3, 0, 0, 1);
    cyc(4'd3, 0, 0, 1);
    cyc(4'd3, 1, 0, 1);
    cyc(4'd4, 1, 0, 1);

    // sw with two wait cycles.
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc(4'd2, 1, 0, 1);
    cyc(4'd5, 0, 0, 1);
    cyc(4'd5, 0, 0, 1);
    cyc(4'd5, 1, 0, 1);

    // beq taken, then not taken.
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc(4'd0, 1, 1, 1);
    cyc(4'd1, 1, 1, 1);
    cyc(4'd9, 1, 1, 1);
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc(4'd9, 1, 0, 1);

    // jal: fetch, decode, jal, writeback.
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc(4'd10, 1, 0, 1);
    cyc(4'd8, 1, 0, 1);

    // R-type with unsupported funct3 traps from EXECR.
    set_instr(7'b0110011, 3'b001, 1'b0);
    cyc(4'd0, 1, 0, 1);
    cyc(4'd1, 1, 0, 1);
    cyc(4'd6, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(4'd11, 1, 1, 1);
    cyc(4'd11, 1, 0, 0);
    cyc(4'd0, 1, 0, 1);

    // Illegal opcode: trap and stay there for 20 cycles, then reset.
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc(4'd1, 1, 0, 1);
    for (int i = 0; i < 20; i++) cyc(4'd11, i[0], 1, 1);
    cyc(4'd11, 1, 0, 0);
    cyc(4'd0, 0, 0, 1);

    @(posedge clk);
    #1;
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
